// File: rtl/lms_adapt_ctrl.sv
// ---------------------------------------------------------------------------
// lms_adapt_ctrl
//
// Sequencer for an LMS adaptive FIR datapath. It tracks a leaky average of
// |e| and steps the filter through coefficient clear, training and tracking.
// It drives the step-size shift, the adaptation enable and the coefficient
// clear pulse, and it detects convergence, divergence and training timeout.
//
// Optional feature macro: LMS_CTRL_STATS_EN adds saturating divergence and
// timeout event counters (o_div_count, o_timeout_count).
//
// Ports:
//   i_clk            system clock
//   i_rst_n          asynchronous active-low reset
//   i_start          one-cycle pulse, (re)starts training from cleared coefs
//   i_freeze         level, suspends adaptation while high (TRAIN/TRACK only)
//   i_sample_valid   qualifies i_e_in, one cycle per sample
//   i_e_in           signed filter error
//   o_adapt_en       enables coefficient accumulation
//   o_mu_shift       step-size shift for the filter
//   o_coef_clr       synchronous coefficient clear to the filter
//   o_converged      high while the loop is tracking
//   o_state_out      current FSM state
//   o_err_avg        unsigned leaky average of |e|
//   o_div_count      (LMS_CTRL_STATS_EN) divergence entries into CLEAR
//   o_timeout_count  (LMS_CTRL_STATS_EN) timeout entries into CLEAR
// ---------------------------------------------------------------------------
module lms_adapt_ctrl #(
    parameter int          W2        = 32,
    parameter int          AVG_SH    = 4,
    parameter int          MU_TRAIN  = 10,
    parameter int          MU_TRACK  = 12,
    parameter int          CONV_THR  = 256,
    parameter logic [31:0] DIV_THR   = 32'h0100_0000,
    parameter int          HOLD      = 64,
    parameter int          MAX_TRAIN = 4096,
    parameter int          CLR_CYC   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_freeze,
    input  logic                 i_sample_valid,
    input  logic signed [W2-1:0] i_e_in,
    output logic                 o_adapt_en,
    output logic [3:0]           o_mu_shift,
    output logic                 o_coef_clr,
    output logic                 o_converged,
    output logic [2:0]           o_state_out,
    output logic [W2-1:0]        o_err_avg
`ifdef LMS_CTRL_STATS_EN
    ,
    output logic [15:0]          o_div_count,
    output logic [15:0]          o_timeout_count
`endif
);

    localparam int CLR_W   = $clog2(CLR_CYC + 1);
    localparam int HOLD_W  = $clog2(HOLD + 1);
    localparam int TRAIN_W = $clog2(MAX_TRAIN + 1);

    localparam logic [W2-1:0]      L_CONV   = W2'(CONV_THR);
    localparam logic [W2-1:0]      L_CONV4  = W2'(4 * CONV_THR);
    localparam logic [W2-1:0]      L_DIV    = W2'(DIV_THR);
    localparam logic [CLR_W-1:0]   L_CLR_LAST = CLR_W'(CLR_CYC - 1);
    localparam logic [HOLD_W-1:0]  L_HOLD   = HOLD_W'(HOLD);
    localparam logic [TRAIN_W-1:0] L_TRAIN_LAST = TRAIN_W'(MAX_TRAIN - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_TRAIN  = 3'd2,
        S_TRACK  = 3'd3,
        S_FREEZE = 3'd4
    } state_t;

    // |e| with the most negative input saturated to the largest positive value
    function automatic logic [W2-1:0] sat_abs(input logic signed [W2-1:0] e);
        logic signed [W2-1:0] neg;
        if (e == {1'b1, {(W2-1){1'b0}}}) begin
            return {1'b0, {(W2-1){1'b1}}};
        end else if (e < 0) begin
            neg = -e;
            return $unsigned(neg);
        end else begin
            return $unsigned(e);
        end
    endfunction

    state_t               r_state, r_saved;
    logic [W2-1:0]        r_avg;
    logic [CLR_W-1:0]     r_clr_cnt;
    logic [HOLD_W-1:0]    r_hold_cnt;
    logic [TRAIN_W-1:0]   r_train_cnt;
    logic                 r_adapt, r_clr, r_conv;
    logic [3:0]           r_mu;

    state_t               w_next, w_saved_nxt;
    logic [CLR_W-1:0]     w_clr_nxt;
    logic [HOLD_W-1:0]    w_hold_nxt;
    logic [TRAIN_W-1:0]   w_train_nxt;
    logic                 w_enter_clr, w_div_evt, w_to_evt;
    logic [W2-1:0]        w_abs, w_avg_upd;
    logic                 w_adapt, w_clr, w_conv;
    logic [3:0]           w_mu;

    // The update cannot overflow: avg - avg/2^k + max/2^k stays below 2^(W2-1).
    assign w_abs     = sat_abs(i_e_in);
    assign w_avg_upd = r_avg - (r_avg >> AVG_SH) + (w_abs >> AVG_SH);

    // Next-state logic; all decisions use the registered average.
    always_comb begin
        w_next      = r_state;
        w_saved_nxt = r_saved;
        w_clr_nxt   = r_clr_cnt;
        w_hold_nxt  = r_hold_cnt;
        w_train_nxt = r_train_cnt;
        w_enter_clr = 1'b0;
        w_div_evt   = 1'b0;
        w_to_evt    = 1'b0;

        if (i_start) begin
            w_enter_clr = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                end
                S_CLEAR: begin
                    if (r_clr_cnt == L_CLR_LAST) begin
                        w_next    = S_TRAIN;
                        w_clr_nxt = '0;
                    end else begin
                        w_clr_nxt = r_clr_cnt + 1'b1;
                    end
                end
                S_TRAIN: begin
                    if (i_freeze) begin
                        w_next      = S_FREEZE;
                        w_saved_nxt = S_TRAIN;
                    end else if (i_sample_valid) begin
                        if (r_avg > L_DIV) begin
                            w_enter_clr = 1'b1;
                            w_div_evt   = 1'b1;
                        end else if (r_hold_cnt >= L_HOLD) begin
                            w_next = S_TRACK;
                        end else begin
                            if (r_avg < L_CONV) begin
                                w_hold_nxt = r_hold_cnt + 1'b1;
                            end else begin
                                w_hold_nxt = '0;
                            end
                            if (r_train_cnt == L_TRAIN_LAST) begin
                                w_enter_clr = 1'b1;
                                w_to_evt    = 1'b1;
                            end else begin
                                w_train_nxt = r_train_cnt + 1'b1;
                            end
                        end
                    end
                end
                S_TRACK: begin
                    if (i_freeze) begin
                        w_next      = S_FREEZE;
                        w_saved_nxt = S_TRACK;
                    end else if (i_sample_valid) begin
                        if (r_avg > L_DIV) begin
                            w_enter_clr = 1'b1;
                            w_div_evt   = 1'b1;
                        end else if (r_avg >= L_CONV4) begin
                            // Hysteresis: fall back to training with fresh counters
                            w_next      = S_TRAIN;
                            w_hold_nxt  = '0;
                            w_train_nxt = '0;
                        end
                    end
                end
                S_FREEZE: begin
                    // Resume without a divergence check on the release cycle
                    if (!i_freeze) begin
                        w_next = r_saved;
                    end
                end
                default: begin
                    w_next = S_IDLE;
                end
            endcase
        end

        if (w_enter_clr) begin
            w_next      = S_CLEAR;
            w_clr_nxt   = '0;
            w_hold_nxt  = '0;
            w_train_nxt = '0;
        end
    end

    // Output decode from the next state so outputs line up with o_state_out
    always_comb begin
        w_adapt = 1'b0;
        w_clr   = 1'b0;
        w_conv  = 1'b0;
        w_mu    = 4'(MU_TRACK);
        case (w_next)
            S_CLEAR: begin
                w_clr = 1'b1;
                w_mu  = 4'(MU_TRAIN);
            end
            S_TRAIN: begin
                w_adapt = 1'b1;
                w_mu    = 4'(MU_TRAIN);
            end
            S_TRACK: begin
                w_adapt = 1'b1;
                w_conv  = 1'b1;
            end
            S_FREEZE: begin
                w_mu   = r_mu;
                w_conv = r_conv;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_saved     <= S_IDLE;
            r_clr_cnt   <= '0;
            r_hold_cnt  <= '0;
            r_train_cnt <= '0;
            r_avg       <= '0;
            r_adapt     <= 1'b0;
            r_clr       <= 1'b0;
            r_conv      <= 1'b0;
            r_mu        <= 4'(MU_TRACK);
        end else begin
            r_state     <= w_next;
            r_saved     <= w_saved_nxt;
            r_clr_cnt   <= w_clr_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_train_cnt <= w_train_nxt;
            r_adapt     <= w_adapt;
            r_clr       <= w_clr;
            r_conv      <= w_conv;
            r_mu        <= w_mu;
            // The average is meaningless while coefficients are being cleared
            if (w_next == S_CLEAR) begin
                r_avg <= '0;
            end else if (i_sample_valid) begin
                r_avg <= w_avg_upd;
            end
        end
    end

    assign o_adapt_en  = r_adapt;
    assign o_mu_shift  = r_mu;
    assign o_coef_clr  = r_clr;
    assign o_converged = r_conv;
    assign o_state_out = r_state;
    assign o_err_avg   = r_avg;

`ifdef LMS_CTRL_STATS_EN
    logic [15:0] r_div_cnt, r_to_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div_cnt <= '0;
            r_to_cnt  <= '0;
        end else begin
            if (w_div_evt && !i_start && r_div_cnt != 16'hFFFF) begin
                r_div_cnt <= r_div_cnt + 16'd1;
            end
            if (w_to_evt && !i_start && r_to_cnt != 16'hFFFF) begin
                r_to_cnt <= r_to_cnt + 16'd1;
            end
        end
    end

    assign o_div_count     = r_div_cnt;
    assign o_timeout_count = r_to_cnt;
`else
    logic w_unused_evt;
    assign w_unused_evt = w_div_evt ^ w_to_evt;
`endif

endmodule

// File: doc/lms_adapt_ctrl.md
Name: lms_adapt_ctrl

Overview:
Sequencer for the LMS adaptive FIR datapath. It watches the filter error output and runs coefficient training and tracking. It drives the step-size shift, the adaptation enable and the coefficient clear. It also detects convergence and divergence, and sits between the system control logic and the filter's e_out, emu and coefficient update path.

Parameters:
W2, 32, error word width (matches the filter output width)
AVG_SH, 4, leaky-average shift; time constant 2^AVG_SH samples
MU_TRAIN, 10, step-size shift (e>>>mu) used while training
MU_TRACK, 12, step-size shift used while tracking or idle
CONV_THR, 256, convergence threshold on err_avg
DIV_THR, 32'h0100_0000, divergence threshold on err_avg
HOLD, 64, consecutive below-threshold samples needed to declare convergence
MAX_TRAIN, 4096, training timeout in samples
CLR_CYC, 16, coefficient-clear pulse length in clocks

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; (re)starts training from cleared coefficients
freeze  in  1  level; suspends adaptation while high
sample_valid  in  1  qualifies e_in, one cycle per sample
e_in  in  W2  signed filter error
adapt_en  out  1  enables coefficient accumulation
mu_shift  out  4  step-size shift for the filter
coef_clr  out  1  synchronous coefficient clear to the filter
converged  out  1  high while the loop is in tracking
state_out  out  3  current FSM state
err_avg  out  W2  unsigned leaky average of |e|

Behaviour:
- Reset (asynchronous, reset=0): state IDLE, adapt_en=0, mu_shift=MU_TRACK, coef_clr=0, converged=0, err_avg=0, all counters 0.
- State encoding: IDLE=0, CLEAR=1, TRAIN=2, TRACK=3, FREEZE=4. Values 5-7 are illegal and recover to IDLE on the next clock.
- All outputs are registered and decoded from the next state, so they change in the same cycle as state_out.
- abs_e = |e_in|. An input of -2^(W2-1) saturates to 2^(W2-1)-1.
- On sample_valid: err_avg <= err_avg - (err_avg>>AVG_SH) + (abs_e>>AVG_SH). The update cannot overflow. err_avg is frozen when sample_valid=0.
- Transition decisions use the registered err_avg, i.e. the value before the current sample's update.
- Priority (highest first): start, freeze, divergence, then the state rules below.
- IDLE: start goes to CLEAR.
- CLEAR: coef_clr=1 and adapt_en=0. err_avg, hold_cnt and train_cnt are zeroed on entry. After exactly CLR_CYC cycles the block goes to TRAIN.
- TRAIN: adapt_en=1, mu_shift=MU_TRAIN. On each valid sample:
  - err_avg > DIV_THR goes to CLEAR.
  - Otherwise, if err_avg < CONV_THR, hold_cnt increments; if not, hold_cnt clears. When hold_cnt reaches HOLD the block goes to TRACK.
  - Otherwise, train_cnt reaching MAX_TRAIN-1 goes to CLEAR (timeout).
- TRACK: adapt_en=1, mu_shift=MU_TRACK, converged=1. On a valid sample:
  - err_avg > DIV_THR goes to CLEAR.
  - err_avg >= 4*CONV_THR (hysteresis) goes to TRAIN with hold_cnt and train_cnt zeroed.
- FREEZE: entered from TRAIN or TRACK when freeze=1; the originating state is saved.
  - adapt_en=0. mu_shift and converged hold their values. err_avg keeps updating and counters hold.
  - When freeze falls, the block returns to the saved state with no divergence check on that cycle.
  - freeze is ignored in IDLE and CLEAR.
- start in any state (including mid-CLEAR) restarts CLEAR with a full CLR_CYC count.
- A reset in mid-operation aborts immediately; no clear pulse is issued.

Optional Feature:
LMS_CTRL_STATS_EN:
- When defined, adds output div_count (16 bits) and output timeout_count (16 bits).
- div_count counts divergence entries into CLEAR; timeout_count counts timeout entries into CLEAR.
- Both saturate at 16'hFFFF and clear on reset only.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Release reset, pulse start -> coef_clr high for exactly 16 clocks, state_out 1; then state_out=2, adapt_en=1, mu_shift=10.
- In TRAIN, drive e_in=0 on every sample -> TRACK on the valid sample after the 64th qualifying one; converged=1, mu_shift=12.
- In TRACK, drive e_in=32'sh4000_0000 until err_avg exceeds 32'h0100_0000 -> next valid sample enters CLEAR, coef_clr pulses 16 clocks, then TRAIN (div_count=1 when the feature is enabled).
- In TRAIN, drive e_in=1000 constantly -> no convergence; after sample 4095 the block enters CLEAR (timeout_count=1).
- Assert freeze for 10 cycles in TRACK -> adapt_en=0, state_out=4, converged stays 1; on release, returns to 3 with mu_shift=12.
- Drive e_in=-2^31 once from err_avg=0 -> err_avg=(2^31-1)>>4=134217727. Separately, pulse start mid-CLEAR -> the 16-clock count restarts.
